// File: rtl/serial_arith_pkg.sv
// ============================================================================
// Module   : serial_arith_pkg
// Brief    : Shared types and full-subtractor helper for the serial arithmetic group.
// Revision : 1.0
// ============================================================================
`default_nettype none

package serial_arith_pkg;

  localparam int unsigned C_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Returns {borrow_out, difference} for one bit slice of x - y - bin.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
    logic d;
    logic bout;
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~x & bin) | (y & bin);
    return {bout, d};
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_subtractor_bit.sv
// ============================================================================
// Module   : full_subtractor_bit
// Brief    : Combinational one-bit full subtractor slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

module full_subtractor_bit
  import serial_arith_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign {bout, d} = full_sub(x, y, bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial A - B, LSB first, with start/busy/done and borrow/ovf flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = C_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int                 C_CNT_W = $clog2(WIDTH) + 1;
  localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_reg_a;
  logic [WIDTH-1:0]   r_reg_b;
  logic [WIDTH-1:0]   r_diff;
  logic [C_CNT_W-1:0] r_count;
  logic               r_brw;
  logic               r_borrow;
  logic               r_ovf;
  logic               r_a_msb;
  logic               r_b_msb;

  logic               w_accept;
  logic               w_last;
  logic               w_d;
  logic               w_bo;

  assign w_accept = start && (r_state != SHIFT);
  assign w_last   = (r_count == C_LAST);

  full_subtractor_bit u_slice (
    .x    (r_reg_a[0]),
    .y    (r_reg_b[0]),
    .bin  (r_brw),
    .d    (w_d),
    .bout (w_bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = start ? SHIFT : IDLE;
      SHIFT:   w_state_next = w_last ? DONE : SHIFT;
      DONE:    w_state_next = start ? SHIFT : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_a  <= '0;
      r_reg_b  <= '0;
      r_diff   <= '0;
      r_count  <= '0;
      r_brw    <= 1'b0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
    end else if (w_accept) begin
      r_reg_a  <= a;
      r_reg_b  <= b;
      r_diff   <= '0;
      r_count  <= '0;
      r_brw    <= 1'b0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_a_msb  <= a[WIDTH-1];
      r_b_msb  <= b[WIDTH-1];
    end else if (r_state == SHIFT) begin
      // Result bits enter at the top so the first (LSB) bit lands in diff[0].
      r_diff  <= {w_d, r_diff[WIDTH-1:1]};
      r_reg_a <= r_reg_a >> 1;
      r_reg_b <= r_reg_b >> 1;
      r_brw   <= w_bo;
      r_count <= r_count + C_CNT_W'(1);
      if (w_last) begin
        r_borrow <= w_bo;
        r_ovf    <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
      end
    end
  end

  assign diff   = r_diff;
  assign borrow = r_borrow;
  assign ovf    = r_ovf;
  assign busy   = (r_state == SHIFT);
  assign done   = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Scoreboard bench for serial_subtractor at WIDTH=4 and WIDTH=8.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  typedef struct {
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic [3:0] diff4;
  logic       borrow4, ovf4, busy4, done4;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic [7:0] diff8;
  logic       borrow8, ovf8, busy8, done8;

  exp_t q4[$];
  exp_t q8[$];
  exp_t e4, e8, tmp;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .diff(diff4), .borrow(borrow4), .ovf(ovf4), .busy(busy4), .done(done4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .diff(diff8), .borrow(borrow8), .ovf(ovf8), .busy(busy8), .done(done8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitors: pop the oldest expectation whenever the DUT signals done.
  initial forever begin
    @(posedge clk);
    #2;
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done4_unexpected: got done=1 expected done=0 at cycle %0d", cyc);
      end else begin
        e4 = q4.pop_front();
        chk("diff4", 32'(diff4), 32'(e4.diff[3:0]));
        chk("borrow4", 32'(borrow4), 32'(e4.borrow));
        chk("ovf4", 32'(ovf4), 32'(e4.ovf));
        chk("latency4", 32'(cyc), 32'(e4.cyc));
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done8_unexpected: got done=1 expected done=0 at cycle %0d", cyc);
      end else begin
        e8 = q8.pop_front();
        chk("diff8", 32'(diff8), 32'(e8.diff));
        chk("borrow8", 32'(borrow8), 32'(e8.borrow));
        chk("ovf8", 32'(ovf8), 32'(e8.ovf));
        chk("latency8", 32'(cyc), 32'(e8.cyc));
      end
    end
  end

  task automatic push4(input logic [3:0] d, input logic br, input logic ov, input int at);
    exp_t e;
    e.diff   = {4'h0, d};
    e.borrow = br;
    e.ovf    = ov;
    e.cyc    = at;
    q4.push_back(e);
  endtask

  // One-cycle start; returns at the negedge after the accepting edge.
  task automatic issue4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] d, input logic br, input logic ov);
    @(negedge clk);
    a4 = a;
    b4 = b;
    start4 = 1'b1;
    push4(d, br, ov, cyc + 1 + 4);
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q4.size() != 0 || q8.size() != 0); i++) @(negedge clk);
    if (q4.size() != 0 || q8.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", q4.size(), q8.size());
      q4.delete();
      q8.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_diff4", 32'(diff4), 32'h0);
    chk("rst_flags4", 32'({borrow4, ovf4, busy4, done4}), 32'h0);
    chk("rst_diff8", 32'(diff8), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 5 - 3 with busy/done timing walk
    issue4(4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("busy_walk", 32'(busy4), 32'(i < 4));
      chk("done_walk", 32'(done4), 32'(i == 4));
      @(negedge clk);
    end
    drain();

    issue4(4'b0011, 4'b0101, 4'b1110, 1'b1, 1'b0);
    drain();
    issue4(4'b0111, 4'b1000, 4'b1111, 1'b1, 1'b1);
    drain();
    issue4(4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1);
    drain();

    // Start re-pulsed mid-SHIFT must be ignored
    issue4(4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0);
    @(negedge clk);
    a4 = 4'b1111;
    b4 = 4'b0001;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    drain();
    repeat (8) @(negedge clk);
    chk("hold_diff4", 32'(diff4), 32'h2);

    // Start held high: back-to-back results WIDTH+1 cycles apart
    @(negedge clk);
    a4 = 4'b1111;
    b4 = 4'b0001;
    start4 = 1'b1;
    push4(4'b1110, 1'b0, 1'b0, cyc + 1 + 4);
    push4(4'b1110, 1'b0, 1'b0, cyc + 1 + 9);
    repeat (6) @(negedge clk);
    start4 = 1'b0;
    drain();

    // Asynchronous reset mid-SHIFT, no done for the aborted operation
    @(negedge clk);
    a4 = 4'b0101;
    b4 = 4'b0011;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_diff4", 32'(diff4), 32'h0);
    chk("abort_flags4", 32'({borrow4, ovf4, busy4, done4}), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    a4 = 4'b0000;
    b4 = 4'b0000;
    start4 = 1'b1;
    push4(4'b0000, 1'b0, 1'b0, cyc + 1 + 4);
    @(negedge clk);
    start4 = 1'b0;
    drain();
    repeat (4) @(negedge clk);

    // WIDTH=8: 0x00 - 0x01
    @(negedge clk);
    a8 = 8'h00;
    b8 = 8'h01;
    start8 = 1'b1;
    tmp.diff = 8'hFF;
    tmp.borrow = 1'b1;
    tmp.ovf = 1'b0;
    tmp.cyc = cyc + 1 + 8;
    q8.push_back(tmp);
    @(negedge clk);
    start8 = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
